egg_countdown: RTL and testbench

Countdown core of the egg timer. It consumes the MM:SS BCD value from the switch-entry stage and runs the 1 Hz countdown from CLOCK_50. It also handles pause/resume and drives the expiry flash. The BCD outputs feed the seven-segment decoders, and `flash_on` drives LEDR.

---
 rtl/egg_countdown.sv | 187 ++++++++++++++++++
 tb/tb_egg_countdown.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/egg_countdown.sv
// egg_countdown: loads a sanitised MM:SS BCD value, counts it down at 1 Hz,
// supports pause/resume, and flashes on expiry until cleared or reloaded.
module egg_countdown #(
    parameter int unsigned TICKS_PER_SEC = 50_000_000,
    parameter int unsigned FLASH_TICKS   = 25_000_000
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic       load,
    input  logic [7:0] min_in,
    input  logic [7:0] sec_in,
    input  logic       start,
    input  logic       clear,
    output logic [7:0] min_q,
    output logic [7:0] sec_q,
    output logic [2:0] state_q,
    output logic       running,
    output logic       tick,
    output logic       done,
    output logic       flash_on
);

    localparam int unsigned PW = $clog2(TICKS_PER_SEC + 1);
    localparam int unsigned FW = $clog2(FLASH_TICKS + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'b000,
        READY = 3'b011,
        RUN   = 3'b010,
        PAUSE = 3'b110,
        FLASH = 3'b100
    } state_t;

    state_t          state, state_d;
    logic [7:0]      min_d, sec_d;
    logic [PW-1:0]   presc, presc_d;
    logic [FW-1:0]   fcnt, fcnt_d;
    logic            tick_d, done_d, flash_d, running_d;
    logic [15:0]     dec_val;
    logic [7:0]      min_san, sec_san;

    // Clamp a BCD digit to an upper limit.
    function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] lim);
        return (d > lim) ? lim : d;
    endfunction

    // BCD MM:SS minus one second; only used on a non-zero value.
    function automatic logic [15:0] bcd_dec(input logic [7:0] m, input logic [7:0] s);
        logic [7:0] mn;
        logic [7:0] sn;
        mn = m;
        sn = s;
        if (s[3:0] != 4'd0) begin
            sn[3:0] = s[3:0] - 4'd1;
        end else if (s[7:4] != 4'd0) begin
            sn[7:4] = s[7:4] - 4'd1;
            sn[3:0] = 4'd9;
        end else begin
            sn = 8'h59;
            if (m[3:0] != 4'd0) begin
                mn[3:0] = m[3:0] - 4'd1;
            end else begin
                mn[7:4] = m[7:4] - 4'd1;
                mn[3:0] = 4'd9;
            end
        end
        return {mn, sn};
    endfunction

    assign min_san = {clamp_digit(min_in[7:4], 4'd9), clamp_digit(min_in[3:0], 4'd9)};
    assign sec_san = {clamp_digit(sec_in[7:4], 4'd5), clamp_digit(sec_in[3:0], 4'd9)};
    assign dec_val = bcd_dec(min_q, sec_q);
    assign state_q = state;

    // Next-state, datapath and pulse logic; clear beats load beats start.
    always_comb begin
        state_d = state;
        min_d   = min_q;
        sec_d   = sec_q;
        presc_d = presc;
        fcnt_d  = fcnt;
        tick_d  = 1'b0;
        done_d  = 1'b0;
        flash_d = flash_on;
        if (clear) begin
            state_d = IDLE;
            min_d   = 8'h00;
            sec_d   = 8'h00;
            presc_d = '0;
            fcnt_d  = '0;
            flash_d = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        min_d   = min_san;
                        sec_d   = sec_san;
                        state_d = READY;
                    end
                end
                READY: begin
                    if (load) begin
                        min_d = min_san;
                        sec_d = sec_san;
                    end else if (start && ({min_q, sec_q} != 16'h0000)) begin
                        state_d = RUN;
                        presc_d = '0;
                    end
                end
                RUN: begin
                    if (presc == PW'(TICKS_PER_SEC - 1)) begin
                        presc_d = '0;
                        min_d   = dec_val[15:8];
                        sec_d   = dec_val[7:0];
                        tick_d  = 1'b1;
                        if (dec_val == 16'h0000) begin
                            state_d = FLASH;
                            done_d  = 1'b1;
                            fcnt_d  = '0;
                            flash_d = 1'b1;
                        end
                    end else begin
                        presc_d = presc + PW'(1);
                    end
                    // Expiry takes precedence over a pause request on the same edge.
                    if (start && (state_d == RUN)) begin
                        state_d = PAUSE;
                    end
                end
                PAUSE: begin
                    if (start) begin
                        state_d = RUN;
                    end
                end
                FLASH: begin
                    if (load) begin
                        min_d   = min_san;
                        sec_d   = sec_san;
                        state_d = READY;
                        fcnt_d  = '0;
                        flash_d = 1'b0;
                    end else if (fcnt == FW'(FLASH_TICKS - 1)) begin
                        fcnt_d  = '0;
                        flash_d = ~flash_on;
                    end else begin
                        fcnt_d = fcnt + FW'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    min_d   = 8'h00;
                    sec_d   = 8'h00;
                    presc_d = '0;
                    fcnt_d  = '0;
                    flash_d = 1'b0;
                end
            endcase
        end
        running_d = (state_d == RUN);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            state    <= IDLE;
            min_q    <= 8'h00;
            sec_q    <= 8'h00;
            presc    <= '0;
            fcnt     <= '0;
            running  <= 1'b0;
            tick     <= 1'b0;
            done     <= 1'b0;
            flash_on <= 1'b0;
        end else begin
            state    <= state_d;
            min_q    <= min_d;
            sec_q    <= sec_d;
            presc    <= presc_d;
            fcnt     <= fcnt_d;
            running  <= running_d;
            tick     <= tick_d;
            done     <= done_d;
            flash_on <= flash_d;
        end
    end

endmodule

// File: tb/tb_egg_countdown.sv
// Bench for egg_countdown: seconds-based reference model checked every cycle,
// plus directed checks with hand-computed values.
module tb_egg_countdown;

    localparam int unsigned T = 4;
    localparam int unsigned F = 2;

    localparam int S_IDLE  = 0;
    localparam int S_READY = 3;
    localparam int S_RUN   = 2;
    localparam int S_PAUSE = 6;
    localparam int S_FLASH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load = 1'b0, start = 1'b0, clear = 1'b0;
    logic [7:0] min_in = 8'h00, sec_in = 8'h00;
    logic [7:0] min_q, sec_q;
    logic [2:0] state_q;
    logic       running, tick, done, flash_on;

    int total = 0;
    int passed = 0;

    // Reference model state: remaining time in plain seconds.
    int m_state = S_IDLE;
    int m_secs  = 0;
    int m_run   = 0;
    int m_fk    = 0;
    bit m_tick  = 0, m_done = 0, m_flash = 0;

    egg_countdown #(.TICKS_PER_SEC(T), .FLASH_TICKS(F)) dut (
        .CLOCK_50(clk), .RESET_N(rst_n), .load(load), .min_in(min_in), .sec_in(sec_in),
        .start(start), .clear(clear), .min_q(min_q), .sec_q(sec_q), .state_q(state_q),
        .running(running), .tick(tick), .done(done), .flash_on(flash_on)
    );

    always #5 clk = ~clk;

    function automatic int min_i(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int load_secs(input logic [7:0] mi, input logic [7:0] si);
        int mt, mo, st, so;
        mt = min_i(int'(mi) / 16, 9);
        mo = min_i(int'(mi) % 16, 9);
        st = min_i(int'(si) / 16, 5);
        so = min_i(int'(si) % 16, 9);
        return (mt * 10 + mo) * 60 + st * 10 + so;
    endfunction

    function automatic logic [7:0] to_bcd(input int v);
        return 8'((v / 10) * 16 + (v % 10));
    endfunction

    function automatic logic [21:0] model_vec();
        return {3'(m_state), to_bcd(m_secs / 60), to_bcd(m_secs % 60), m_tick, m_done, m_flash};
    endfunction

    function automatic logic [21:0] dut_vec();
        return {state_q, min_q, sec_q, tick, done, flash_on};
    endfunction

    // Model advances on each clock edge from the sampled inputs.
    always @(posedge clk) begin
        m_tick = 0;
        m_done = 0;
        if (!rst_n) begin
            m_state = S_IDLE; m_secs = 0; m_run = 0; m_fk = 0; m_flash = 0;
        end else if (clear) begin
            m_state = S_IDLE; m_secs = 0; m_run = 0; m_fk = 0; m_flash = 0;
        end else begin
            case (m_state)
                S_IDLE:  if (load) begin m_secs = load_secs(min_in, sec_in); m_state = S_READY; end
                S_READY: begin
                    if (load) m_secs = load_secs(min_in, sec_in);
                    else if (start && m_secs != 0) begin m_state = S_RUN; m_run = 0; end
                end
                S_RUN: begin
                    m_run++;
                    if (m_run == T) begin
                        m_run = 0;
                        m_secs--;
                        m_tick = 1;
                        if (m_secs == 0) begin
                            m_state = S_FLASH; m_done = 1; m_fk = 0; m_flash = 1;
                        end
                    end
                    if (start && m_state == S_RUN) m_state = S_PAUSE;
                end
                S_PAUSE: if (start) m_state = S_RUN;
                S_FLASH: begin
                    if (load) begin
                        m_secs = load_secs(min_in, sec_in); m_state = S_READY; m_flash = 0;
                    end else begin
                        m_fk++;
                        m_flash = ((m_fk / F) % 2) == 0;
                    end
                end
                default: m_state = S_IDLE;
            endcase
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        total++;
        if (dut_vec() === model_vec() && running === (m_state == S_RUN)) passed++;
        else $display("FAIL cycle_compare t=%0t: got st=%0h mm=%0h ss=%0h tk=%0b dn=%0b fl=%0b run=%0b, expected %0h run=%0b",
                      $time, state_q, min_q, sec_q, tick, done, flash_on, running, model_vec(), (m_state == S_RUN));
    end

    // Directed check: DUT and model both against a hand-computed vector.
    task automatic chk(input string name, input logic [2:0] st, input logic [7:0] mm,
                       input logic [7:0] ss, input logic tk, input logic dn, input logic fl);
        logic [21:0] exp;
        exp = {st, mm, ss, tk, dn, fl};
        total++;
        if (dut_vec() === exp) passed++;
        else $display("FAIL %s dut: got %06h expected %06h", name, dut_vec(), exp);
        total++;
        if (model_vec() === exp) passed++;
        else $display("FAIL %s model: got %06h expected %06h", name, model_vec(), exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input logic l, input logic s, input logic c,
                         input logic [7:0] mi, input logic [7:0] si);
        load = l; start = s; clear = c; min_in = mi; sec_in = si;
        @(negedge clk);
        load = 0; start = 0; clear = 0;
    endtask

    initial begin
        rst_n = 0;
        cyc(3);
        chk("reset", 3'b000, 8'h00, 8'h00, 0, 0, 0);
        rst_n = 1;

        // Basic run 00:03.
        drive(1, 0, 0, 8'h00, 8'h03);
        chk("load_0003", 3'b011, 8'h00, 8'h03, 0, 0, 0);
        drive(0, 1, 0, 8'h00, 8'h00);
        chk("run_entry", 3'b010, 8'h00, 8'h03, 0, 0, 0);
        cyc(3);
        chk("pre_tick", 3'b010, 8'h00, 8'h03, 0, 0, 0);
        cyc(1);
        chk("tick1", 3'b010, 8'h00, 8'h02, 1, 0, 0);
        cyc(4);
        chk("tick2", 3'b010, 8'h00, 8'h01, 1, 0, 0);
        cyc(4);
        chk("tick3_done", 3'b100, 8'h00, 8'h00, 1, 1, 1);
        cyc(1); chk("flash_1", 3'b100, 8'h00, 8'h00, 0, 0, 1);
        cyc(1); chk("flash_2", 3'b100, 8'h00, 8'h00, 0, 0, 0);
        cyc(1); chk("flash_3", 3'b100, 8'h00, 8'h00, 0, 0, 0);
        cyc(1); chk("flash_4", 3'b100, 8'h00, 8'h00, 0, 0, 1);
        drive(0, 1, 0, 8'h00, 8'h00);
        chk("flash_start_ignored", 3'b100, 8'h00, 8'h00, 0, 0, 1);

        // clear and load together in FLASH.
        drive(1, 0, 1, 8'h12, 8'h34);
        chk("clear_over_load", 3'b000, 8'h00, 8'h00, 0, 0, 0);
        drive(0, 1, 0, 8'h00, 8'h00);
        chk("idle_start_ignored", 3'b000, 8'h00, 8'h00, 0, 0, 0);

        // Borrow chain 10:00 -> 09:59.
        drive(1, 0, 0, 8'h10, 8'h00);
        drive(0, 1, 0, 8'h00, 8'h00);
        cyc(4);
        chk("borrow", 3'b010, 8'h09, 8'h59, 1, 0, 0);
        drive(1, 0, 0, 8'h00, 8'h07);
        chk("run_load_ignored", 3'b010, 8'h09, 8'h59, 0, 0, 0);
        drive(0, 0, 1, 8'h00, 8'h00);
        chk("clear_run", 3'b000, 8'h00, 8'h00, 0, 0, 0);

        // Pause keeps the partial second.
        drive(1, 0, 0, 8'h00, 8'h02);
        drive(0, 1, 0, 8'h00, 8'h00);
        cyc(1);
        drive(0, 1, 0, 8'h00, 8'h00);
        chk("paused", 3'b110, 8'h00, 8'h02, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            if (tick !== 1'b0) begin
                total++;
                $display("FAIL pause_no_tick: got tick=%0b required 0", tick);
            end
        end
        drive(0, 1, 0, 8'h00, 8'h00);
        chk("resume", 3'b010, 8'h00, 8'h02, 0, 0, 0);
        cyc(1);
        chk("resume_plus1", 3'b010, 8'h00, 8'h02, 0, 0, 0);
        cyc(1);
        chk("resume_plus2", 3'b010, 8'h00, 8'h01, 1, 0, 0);
        drive(0, 0, 1, 8'h00, 8'h00);

        // start coinciding with a wrap: decrement and pause together.
        drive(1, 0, 0, 8'h00, 8'h03);
        drive(0, 1, 0, 8'h00, 8'h00);
        cyc(3);
        drive(0, 1, 0, 8'h00, 8'h00);
        chk("start_at_wrap", 3'b110, 8'h00, 8'h02, 1, 0, 0);
        drive(0, 0, 1, 8'h00, 8'h00);

        // Clamp and zero-load.
        drive(1, 0, 0, 8'hAF, 8'h9A);
        chk("clamp", 3'b011, 8'h99, 8'h59, 0, 0, 0);
        drive(1, 0, 0, 8'h00, 8'h7C);
        chk("clamp_7c", 3'b011, 8'h00, 8'h59, 0, 0, 0);
        drive(1, 0, 0, 8'h00, 8'h00);
        drive(0, 1, 0, 8'h00, 8'h00);
        chk("zero_start", 3'b011, 8'h00, 8'h00, 0, 0, 0);

        // load and start together in READY.
        drive(1, 1, 0, 8'h00, 8'h05);
        chk("load_over_start", 3'b011, 8'h00, 8'h05, 0, 0, 0);

        // Reset mid-run.
        drive(0, 1, 0, 8'h00, 8'h00);
        cyc(2);
        rst_n = 0;
        cyc(2);
        rst_n = 1;
        chk("reset_mid_run", 3'b000, 8'h00, 8'h00, 0, 0, 0);
        drive(0, 1, 0, 8'h00, 8'h00);
        chk("reset_start_ignored", 3'b000, 8'h00, 8'h00, 0, 0, 0);

        // Load from FLASH goes to READY.
        drive(1, 0, 0, 8'h00, 8'h01);
        drive(0, 1, 0, 8'h00, 8'h00);
        cyc(4);
        chk("expire_0001", 3'b100, 8'h00, 8'h00, 1, 1, 1);
        drive(1, 0, 0, 8'h01, 8'h30);
        chk("flash_load", 3'b011, 8'h01, 8'h30, 0, 0, 0);
        cyc(2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
